gerenciador_memoria_acesso: RTL and testbench

Memory responder for the pathfinding datapath: owns the graph-relations, obstacle and established-node memories and serves the read/write requests issued by `localizador_vizinhos_validos` and the expansion controller. It also accepts graph loading from the configuration side and clears the established-node memory after reset or on command. The module sits between the configuration loader and the search core, and is the sole owner of these three arrays.

---
 rtl/gerenciador_memoria_acesso_pkg.sv | 13 +
 rtl/gerenciador_memoria_acesso_if.sv | 58 +++++
 rtl/gerenciador_memoria_acesso_ram_1r1w.sv | 35 +++
 rtl/gerenciador_memoria_acesso.sv | 108 ++++++++++
 tb/tb_gerenciador_memoria_acesso.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/gerenciador_memoria_acesso_pkg.sv
// Shared types for the memory responder: controller states and load-target selectors.
package gma_pkg;

  typedef enum logic [1:0] {
    LIMPEZA = 2'd0,
    PRONTO  = 2'd1,
    CARGA   = 2'd2
  } estado_t;

  localparam logic SEL_RELACOES   = 1'b0;
  localparam logic SEL_OBSTACULOS = 1'b1;

endpackage

// File: rtl/gerenciador_memoria_acesso_if.sv
// Bundle of configuration-load and search-side memory access signals.
interface gerenciador_memoria_acesso_if #(
  parameter int ADDR_WIDTH          = 8,
  parameter int RELACOES_DATA_WIDTH = 8,
  parameter int DATA_WIDTH          = 4
);

  logic                           cfg_carga_valid_in;
  logic                           cfg_carga_sel_in;
  logic [ADDR_WIDTH-1:0]          cfg_carga_addr_in;
  logic [RELACOES_DATA_WIDTH-1:0] cfg_carga_data_in;
  logic                           cfg_carga_fim_in;
  logic                           cfg_carga_ready_out;
  logic                           cfg_limpar_in;
  logic                           gma_pronto_out;

  logic                           lvv_relacoes_rd_enable_in;
  logic [ADDR_WIDTH-1:0]          lvv_relacoes_rd_addr_in;
  logic [RELACOES_DATA_WIDTH-1:0] gma_relacoes_rd_data_out;

  logic                           lvv_obstaculos_rd_enable_in;
  logic [ADDR_WIDTH-1:0]          lvv_obstaculos_rd_addr_in;
  logic                           gma_obstaculos_rd_data_out;

  logic                           lvv_estabelecidos_write_en_in;
  logic [ADDR_WIDTH-1:0]          lvv_estabelecidos_write_addr_in;
  logic [DATA_WIDTH-1:0]          lvv_estabelecidos_write_data_in;
  logic                           cme_estabelecidos_rd_enable_in;
  logic [ADDR_WIDTH-1:0]          cme_estabelecidos_rd_addr_in;
  logic [DATA_WIDTH-1:0]          gma_estabelecidos_rd_data_out;

  modport master (
    output cfg_carga_valid_in, cfg_carga_sel_in, cfg_carga_addr_in, cfg_carga_data_in,
           cfg_carga_fim_in, cfg_limpar_in,
           lvv_relacoes_rd_enable_in, lvv_relacoes_rd_addr_in,
           lvv_obstaculos_rd_enable_in, lvv_obstaculos_rd_addr_in,
           lvv_estabelecidos_write_en_in, lvv_estabelecidos_write_addr_in,
           lvv_estabelecidos_write_data_in,
           cme_estabelecidos_rd_enable_in, cme_estabelecidos_rd_addr_in,
    input  cfg_carga_ready_out, gma_pronto_out,
           gma_relacoes_rd_data_out, gma_obstaculos_rd_data_out,
           gma_estabelecidos_rd_data_out
  );

  modport slave (
    input  cfg_carga_valid_in, cfg_carga_sel_in, cfg_carga_addr_in, cfg_carga_data_in,
           cfg_carga_fim_in, cfg_limpar_in,
           lvv_relacoes_rd_enable_in, lvv_relacoes_rd_addr_in,
           lvv_obstaculos_rd_enable_in, lvv_obstaculos_rd_addr_in,
           lvv_estabelecidos_write_en_in, lvv_estabelecidos_write_addr_in,
           lvv_estabelecidos_write_data_in,
           cme_estabelecidos_rd_enable_in, cme_estabelecidos_rd_addr_in,
    output cfg_carga_ready_out, gma_pronto_out,
           gma_relacoes_rd_data_out, gma_obstaculos_rd_data_out,
           gma_estabelecidos_rd_data_out
  );

endinterface

// File: rtl/gerenciador_memoria_acesso_ram_1r1w.sv
// Simple dual-port RAM: synchronous write, registered read-first read with a zero-load override.
module gma_ram_1r1w #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic                  rd_zero_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Array contents are deliberately not reset so loaded graphs survive a reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         rdata_q <= '0;
    else if (rd_zero_i) rdata_q <= '0;
    else if (re_i)      rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gerenciador_memoria_acesso.sv
// Owner of the relations, obstacle and established-node memories; sequences clear, load and search access.
module gerenciador_memoria_acesso
  import gma_pkg::*;
#(
  parameter int ADDR_WIDTH          = 8,
  parameter int RELACOES_DATA_WIDTH = 8,
  parameter int DATA_WIDTH          = 4
) (
  input logic clk,
  input logic rst_n,
  gerenciador_memoria_acesso_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

  estado_t               estado_q, estado_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  carga_aceita;
  logic                  pronto;
  logic                  limpando;
  logic                  est_we;
  logic [ADDR_WIDTH-1:0] est_waddr;
  logic [DATA_WIDTH-1:0] est_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= LIMPEZA;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  // Clear request outranks a load word arriving in the same PRONTO cycle.
  always_comb begin
    estado_d     = estado_q;
    cnt_d        = cnt_q;
    carga_aceita = 1'b0;
    case (estado_q)
      LIMPEZA: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == CNT_MAX) estado_d = PRONTO;
      end
      PRONTO: begin
        if (bus.cfg_limpar_in) begin
          estado_d = LIMPEZA;
        end else if (bus.cfg_carga_valid_in) begin
          estado_d     = CARGA;
          carga_aceita = 1'b1;
        end
      end
      CARGA: begin
        carga_aceita = bus.cfg_carga_valid_in;
        if (bus.cfg_carga_fim_in) estado_d = PRONTO;
      end
      default: estado_d = LIMPEZA;
    endcase
  end

  assign pronto   = (estado_q == PRONTO);
  assign limpando = (estado_q == LIMPEZA);

  assign bus.cfg_carga_ready_out = !limpando;
  assign bus.gma_pronto_out      = pronto;

  // The clear sweep owns the established write port; search writes only land in PRONTO.
  assign est_we    = limpando | (pronto & bus.lvv_estabelecidos_write_en_in);
  assign est_waddr = limpando ? cnt_q : bus.lvv_estabelecidos_write_addr_in;
  assign est_wdata = limpando ? '0 : bus.lvv_estabelecidos_write_data_in;

  gma_ram_1r1w #(.WIDTH(RELACOES_DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_relacoes (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (carga_aceita && (bus.cfg_carga_sel_in == SEL_RELACOES)),
    .waddr_i   (bus.cfg_carga_addr_in),
    .wdata_i   (bus.cfg_carga_data_in),
    .re_i      (bus.lvv_relacoes_rd_enable_in),
    .rd_zero_i (!pronto),
    .raddr_i   (bus.lvv_relacoes_rd_addr_in),
    .rdata_o   (bus.gma_relacoes_rd_data_out)
  );

  gma_ram_1r1w #(.WIDTH(1), .ADDR_WIDTH(ADDR_WIDTH)) u_obstaculos (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (carga_aceita && (bus.cfg_carga_sel_in == SEL_OBSTACULOS)),
    .waddr_i   (bus.cfg_carga_addr_in),
    .wdata_i   (bus.cfg_carga_data_in[0]),
    .re_i      (bus.lvv_obstaculos_rd_enable_in),
    .rd_zero_i (!pronto),
    .raddr_i   (bus.lvv_obstaculos_rd_addr_in),
    .rdata_o   (bus.gma_obstaculos_rd_data_out)
  );

  gma_ram_1r1w #(.WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_estabelecidos (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (est_we),
    .waddr_i   (est_waddr),
    .wdata_i   (est_wdata),
    .re_i      (bus.cme_estabelecidos_rd_enable_in),
    .rd_zero_i (!pronto),
    .raddr_i   (bus.cme_estabelecidos_rd_addr_in),
    .rdata_o   (bus.gma_estabelecidos_rd_data_out)
  );

endmodule

// File: tb/tb_gerenciador_memoria_acesso.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural memory model.
module tb_gerenciador_memoria_acesso;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;

  gerenciador_memoria_acesso_if #(.ADDR_WIDTH(8), .RELACOES_DATA_WIDTH(8), .DATA_WIDTH(4)) bus ();

  gerenciador_memoria_acesso #(.ADDR_WIDTH(8), .RELACOES_DATA_WIDTH(8), .DATA_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0] mRel [256];
  logic       mObs [256];
  logic [3:0] mEst [256];
  int         clearLeft;
  bit         loading;
  logic [7:0] eRel;
  logic       eObs;
  logic [3:0] eEst;

  task automatic checkOutput(input string tag, input logic [31:0] obsV, input logic [31:0] expV);
    checkCount++;
    if (obsV !== expV) $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obsV, expV, $time);
    else passCount++;
  endtask

  task automatic checkAll();
    checkOutput("ready",  32'(bus.cfg_carga_ready_out), 32'(clearLeft == 0));
    checkOutput("pronto", 32'(bus.gma_pronto_out), 32'(clearLeft == 0 && !loading));
    checkOutput("relRd",  32'(bus.gma_relacoes_rd_data_out), 32'(eRel));
    checkOutput("obsRd",  32'(bus.gma_obstaculos_rd_data_out), 32'(eObs));
    checkOutput("estRd",  32'(bus.gma_estabelecidos_rd_data_out), 32'(eEst));
  endtask

  task automatic clearInputs();
    bus.cfg_carga_valid_in = 0; bus.cfg_carga_sel_in = 0; bus.cfg_carga_addr_in = 0;
    bus.cfg_carga_data_in = 0;  bus.cfg_carga_fim_in = 0; bus.cfg_limpar_in = 0;
    bus.lvv_relacoes_rd_enable_in = 0;   bus.lvv_relacoes_rd_addr_in = 0;
    bus.lvv_obstaculos_rd_enable_in = 0; bus.lvv_obstaculos_rd_addr_in = 0;
    bus.lvv_estabelecidos_write_en_in = 0; bus.lvv_estabelecidos_write_addr_in = 0;
    bus.lvv_estabelecidos_write_data_in = 0;
    bus.cme_estabelecidos_rd_enable_in = 0; bus.cme_estabelecidos_rd_addr_in = 0;
  endtask

  task automatic modelLoadWord();
    if (bus.cfg_carga_sel_in) mObs[bus.cfg_carga_addr_in] = bus.cfg_carga_data_in[0];
    else                      mRel[bus.cfg_carga_addr_in] = bus.cfg_carga_data_in;
  endtask

  // Advance the model by one cycle using the currently driven inputs, clock once, then compare.
  task automatic applyStimulus();
    if (clearLeft > 0) begin
      eRel = 0; eObs = 0; eEst = 0;
      clearLeft--;
    end else if (loading) begin
      eRel = 0; eObs = 0; eEst = 0;
      if (bus.cfg_carga_valid_in) modelLoadWord();
      if (bus.cfg_carga_fim_in) loading = 0;
    end else begin
      if (bus.lvv_relacoes_rd_enable_in)      eRel = mRel[bus.lvv_relacoes_rd_addr_in];
      if (bus.lvv_obstaculos_rd_enable_in)    eObs = mObs[bus.lvv_obstaculos_rd_addr_in];
      if (bus.cme_estabelecidos_rd_enable_in) eEst = mEst[bus.cme_estabelecidos_rd_addr_in];
      if (bus.lvv_estabelecidos_write_en_in)
        mEst[bus.lvv_estabelecidos_write_addr_in] = bus.lvv_estabelecidos_write_data_in;
      if (bus.cfg_limpar_in) begin
        clearLeft = 256;
        for (int i = 0; i < 256; i++) mEst[i] = 0;
      end else if (bus.cfg_carga_valid_in) begin
        modelLoadWord();
        loading = 1;
      end
    end
    @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    clearInputs();
    rst_n = 0;
    #2;
    clearLeft = 256; loading = 0; eRel = 0; eObs = 0; eEst = 0;
    for (int i = 0; i < 256; i++) mEst[i] = 0;
    checkAll();
    @(negedge clk);
    rst_n = 1;
    #1;
    checkAll();
  endtask

  task automatic waitPronto(input string tag);
    int n = 0;
    clearInputs();
    while (bus.gma_pronto_out !== 1'b1 && n < 400) begin
      applyStimulus();
      n++;
    end
    checkOutput(tag, 32'(n), 32'd256);
  endtask

  task automatic loadWord(input logic sel, input logic [7:0] addr, input logic [7:0] data, input logic fim);
    bus.cfg_carga_valid_in = 1; bus.cfg_carga_sel_in = sel;
    bus.cfg_carga_addr_in = addr; bus.cfg_carga_data_in = data; bus.cfg_carga_fim_in = fim;
    applyStimulus();
    clearInputs();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clearInputs();
    for (int i = 0; i < 256; i++) begin mRel[i] = 0; mObs[i] = 0; mEst[i] = 0; end

    // Reset, idle clear, established reads at both ends.
    doReset();
    waitPronto("clearLenReset");
    bus.cme_estabelecidos_rd_enable_in = 1; bus.cme_estabelecidos_rd_addr_in = 8'h00;
    applyStimulus();
    checkOutput("est00", 32'(bus.gma_estabelecidos_rd_data_out), 32'h0);
    bus.cme_estabelecidos_rd_addr_in = 8'hFF;
    bus.lvv_estabelecidos_write_en_in = 0;
    applyStimulus();
    checkOutput("estFF", 32'(bus.gma_estabelecidos_rd_data_out), 32'h0);
    clearInputs();

    // Preload every relation and obstacle so random reads have defined contents.
    for (int a = 0; a < 256; a++) loadWord(1'b0, 8'(a), 8'($urandom), 1'b0);
    for (int a = 0; a < 256; a++) loadWord(1'b1, 8'(a), 8'($urandom), a == 255);
    applyStimulus();

    // Load and read back at 0x12.
    loadWord(1'b0, 8'h12, 8'hA5, 1'b0);
    loadWord(1'b1, 8'h12, 8'h01, 1'b1);
    checkOutput("prontoAfterLoad", 32'(bus.gma_pronto_out), 32'h1);
    bus.lvv_relacoes_rd_enable_in = 1;   bus.lvv_relacoes_rd_addr_in = 8'h12;
    bus.lvv_obstaculos_rd_enable_in = 1; bus.lvv_obstaculos_rd_addr_in = 8'h12;
    applyStimulus();
    checkOutput("rel12", 32'(bus.gma_relacoes_rd_data_out), 32'hA5);
    checkOutput("obs12", 32'(bus.gma_obstaculos_rd_data_out), 32'h1);
    clearInputs();
    applyStimulus();
    checkOutput("relHold", 32'(bus.gma_relacoes_rd_data_out), 32'hA5);

    // Read-first collision on established[0x30].
    bus.lvv_estabelecidos_write_en_in = 1; bus.lvv_estabelecidos_write_addr_in = 8'h30;
    bus.lvv_estabelecidos_write_data_in = 4'h7;
    applyStimulus();
    bus.lvv_estabelecidos_write_data_in = 4'h3;
    bus.cme_estabelecidos_rd_enable_in = 1; bus.cme_estabelecidos_rd_addr_in = 8'h30;
    applyStimulus();
    checkOutput("collOld", 32'(bus.gma_estabelecidos_rd_data_out), 32'h7);
    bus.lvv_estabelecidos_write_en_in = 0;
    applyStimulus();
    checkOutput("collNew", 32'(bus.gma_estabelecidos_rd_data_out), 32'h3);
    clearInputs();

    // Search accesses during CARGA are gated.
    loadWord(1'b0, 8'h40, 8'h11, 1'b0);
    bus.lvv_relacoes_rd_enable_in = 1; bus.lvv_relacoes_rd_addr_in = 8'h12;
    bus.lvv_estabelecidos_write_en_in = 1; bus.lvv_estabelecidos_write_addr_in = 8'h31;
    bus.lvv_estabelecidos_write_data_in = 4'h5;
    applyStimulus();
    checkOutput("gatedRel", 32'(bus.gma_relacoes_rd_data_out), 32'h0);
    clearInputs();
    bus.cfg_carga_fim_in = 1;
    applyStimulus();
    clearInputs();
    bus.cme_estabelecidos_rd_enable_in = 1; bus.cme_estabelecidos_rd_addr_in = 8'h31;
    applyStimulus();
    checkOutput("gatedWrite", 32'(bus.gma_estabelecidos_rd_data_out), 32'h0);
    clearInputs();

    // Clear wins over a simultaneous load word.
    bus.cfg_limpar_in = 1;
    bus.cfg_carga_valid_in = 1; bus.cfg_carga_addr_in = 8'h50; bus.cfg_carga_data_in = 8'h99;
    applyStimulus();
    checkOutput("readyDrop", 32'(bus.cfg_carga_ready_out), 32'h0);
    waitPronto("clearLenCmd");
    for (int a = 0; a < 256; a++) begin
      bus.cme_estabelecidos_rd_enable_in = 1; bus.cme_estabelecidos_rd_addr_in = 8'(a);
      bus.lvv_relacoes_rd_enable_in = (a == 8'h50); bus.lvv_relacoes_rd_addr_in = 8'h50;
      applyStimulus();
    end
    clearInputs();

    // Reset in the middle of a load keeps loaded contents.
    loadWord(1'b0, 8'h05, 8'h3C, 1'b0);
    loadWord(1'b1, 8'h05, 8'h00, 1'b0);
    doReset();
    waitPronto("clearLenMidLoad");
    bus.lvv_relacoes_rd_enable_in = 1; bus.lvv_relacoes_rd_addr_in = 8'h05;
    applyStimulus();
    checkOutput("rel05Kept", 32'(bus.gma_relacoes_rd_data_out), 32'h3C);
    clearInputs();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.cfg_limpar_in      = ($urandom_range(0, 399) == 0);
      bus.cfg_carga_valid_in = ($urandom_range(0, 4) == 0);
      bus.cfg_carga_sel_in   = 1'($urandom);
      bus.cfg_carga_addr_in  = 8'($urandom);
      bus.cfg_carga_data_in  = 8'($urandom);
      bus.cfg_carga_fim_in   = (loading && clearLeft == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      bus.lvv_relacoes_rd_enable_in   = 1'($urandom);
      bus.lvv_relacoes_rd_addr_in     = 8'($urandom);
      bus.lvv_obstaculos_rd_enable_in = 1'($urandom);
      bus.lvv_obstaculos_rd_addr_in   = 8'($urandom);
      bus.lvv_estabelecidos_write_en_in   = 1'($urandom);
      bus.lvv_estabelecidos_write_addr_in = 8'($urandom_range(0, 15));
      bus.lvv_estabelecidos_write_data_in = 4'($urandom);
      bus.cme_estabelecidos_rd_enable_in  = 1'($urandom);
      bus.cme_estabelecidos_rd_addr_in    = 8'($urandom_range(0, 15));
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
